// File: rtl/fetch_queue.sv
// Instruction fetch unit: issues memory requests over a req/gnt/rvalid handshake and
// buffers responses with their PCs in an in-order prefetch queue, flushing on redirect.
module fetch_queue #(
    parameter int                 ADDR_W   = 32,
    parameter int                 DATA_W   = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                      CLK,
    input  logic                      Reset,
    output logic [ADDR_W-1:0]         Instr_Addr,
    output logic                      imem_req,
    input  logic                      imem_gnt,
    input  logic                      imem_rvalid,
    input  logic [DATA_W-1:0]         imem_rdata,
    input  logic                      redirect,
    input  logic [ADDR_W-1:0]         redirect_pc,
    output logic                      instr_valid,
    output logic [DATA_W-1:0]         instr,
    output logic [ADDR_W-1:0]         instr_pc,
    input  logic                      instr_ready,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] resp_pc_q;     // PC of the next response that will be kept
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  inflight_q;
    logic [PTR_W-1:0]  discard_q;
    logic [PTR_W-1:0]  inflight_d;
    logic [PTR_W:0]    committed;
    logic [ADDR_W-1:0] redirect_aligned;

    logic [DATA_W-1:0] mem_instr [DEPTH];
    logic [ADDR_W-1:0] mem_pc    [DEPTH];

    logic fire;
    logic keep;
    logic pop;

    assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

    assign occupancy   = wr_ptr_q - rd_ptr_q;
    assign instr_valid = (wr_ptr_q != rd_ptr_q);
    assign instr       = instr_valid ? mem_instr[rd_ptr_q[IDX_W-1:0]] : '0;
    assign instr_pc    = instr_valid ? mem_pc[rd_ptr_q[IDX_W-1:0]]    : '0;

    // Queued entries plus outstanding requests never exceed DEPTH, so overflow cannot occur.
    assign committed  = {1'b0, occupancy} + {1'b0, inflight_q};
    assign imem_req   = Reset & ~redirect & (committed < (PTR_W+1)'(DEPTH));
    assign Instr_Addr = pc_q;

    assign fire = imem_req & imem_gnt;
    assign keep = imem_rvalid & (discard_q == '0) & ~redirect;
    assign pop  = instr_valid & instr_ready & ~redirect;

    always_comb begin
        inflight_d = inflight_q;
        if (fire && !imem_rvalid)
            inflight_d = inflight_q + PTR_W'(1);
        else if (!fire && imem_rvalid)
            inflight_d = inflight_q - PTR_W'(1);
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            pc_q       <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            inflight_q <= inflight_d;
            if (redirect) begin
                // Everything still outstanding belongs to the abandoned stream.
                pc_q      <= redirect_aligned;
                resp_pc_q <= redirect_aligned;
                rd_ptr_q  <= wr_ptr_q;
                discard_q <= inflight_d;
            end else begin
                if (fire)
                    pc_q <= pc_q + ADDR_W'(4);
                if (keep) begin
                    wr_ptr_q  <= wr_ptr_q + PTR_W'(1);
                    resp_pc_q <= resp_pc_q + ADDR_W'(4);
                end
                if (pop)
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                if (imem_rvalid && discard_q != '0)
                    discard_q <= discard_q - PTR_W'(1);
            end
        end
    end

    // NOTE: the storage array is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge CLK) begin
        if (keep) begin
            mem_instr[wr_ptr_q[IDX_W-1:0]] <= imem_rdata;
            mem_pc[wr_ptr_q[IDX_W-1:0]]    <= resp_pc_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            assert (!(imem_rvalid && inflight_q == '0));
            assert (!(keep && !pop && occupancy == PTR_W'(DEPTH)));
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a queue-based reference model.
module tb_fetch_queue;

    localparam int          ADDR_W   = 32;
    localparam int          DATA_W   = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic              CLK = 1'b0;
    logic              Reset = 1'b0;
    logic [ADDR_W-1:0] Instr_Addr;
    logic              imem_req;
    logic              imem_gnt = 1'b0;
    logic              imem_rvalid = 1'b0;
    logic [DATA_W-1:0] imem_rdata = '0;
    logic              redirect = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready = 1'b0;
    logic [$clog2(DEPTH):0] occupancy;

    fetch_queue #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .CLK(CLK), .Reset(Reset), .Instr_Addr(Instr_Addr), .imem_req(imem_req),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready), .occupancy(occupancy)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [31:0] pc; logic [31:0] data; } entry_t;
    typedef struct { logic [31:0] pc; bit stale; } req_t;
    typedef struct { logic [31:0] addr; int due; } mem_t;
    typedef struct {
        bit gnt; bit rv; bit rdy;
        bit exp_req; logic [31:0] exp_addr; bit exp_valid; logic [31:0] exp_pc; int exp_occ;
    } vec_t;

    entry_t      m_q[$];     // reference queue contents
    req_t        m_fl[$];    // reference in-flight requests, oldest first
    logic [31:0] m_pc;
    mem_t        mem_q[$];   // memory: accepted requests awaiting response
    int          mem_lat_max = 1;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          grants = 0;
    int          delivered = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
    endfunction

    function automatic bit rv_auto();
        return mem_q.size() > 0 && mem_q[0].due <= cyc;
    endfunction

    // One clock cycle: drive inputs, compare against the model, advance model and memory.
    task automatic step(input bit gnt, input bit rv, input bit rdy, input bit redir,
                        input logic [31:0] rpc);
        req_t r;
        bit   exp_req;
        bit   keep;
        int   occ;
        @(negedge CLK);
        imem_gnt    = gnt;
        instr_ready = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        imem_rvalid = rv && mem_q.size() > 0;
        imem_rdata  = imem_rvalid ? mem_word(mem_q[0].addr) : $urandom();
        #1;
        occ     = m_q.size();
        exp_req = !redir && (occ + m_fl.size() < DEPTH);
        check("imem_req", imem_req, exp_req);
        check("Instr_Addr", Instr_Addr, m_pc);
        check("instr_valid", instr_valid, occ > 0);
        check("instr_pc", instr_pc, occ > 0 ? m_q[0].pc : 32'h0);
        check("instr", instr, occ > 0 ? m_q[0].data : 32'h0);
        check("occupancy", occupancy, occ);
        if (instr_valid && rdy && !redir) delivered++;
        if (imem_rvalid) void'(mem_q.pop_front());
        if (imem_req && imem_gnt) begin
            grants++;
            mem_q.push_back(mem_t'{Instr_Addr, cyc + $urandom_range(1, mem_lat_max)});
        end
        keep = 1'b0;
        if (imem_rvalid && m_fl.size() > 0) begin
            r    = m_fl.pop_front();
            keep = !r.stale && !redir;
        end
        if (redir) begin
            m_q.delete();
            foreach (m_fl[i]) m_fl[i].stale = 1'b1;
            m_pc = rpc & ~32'h3;
        end else begin
            if (occ > 0 && rdy) void'(m_q.pop_front());
            if (keep) m_q.push_back(entry_t'{r.pc, imem_rdata});
            if (exp_req && gnt) begin
                m_fl.push_back(req_t'{m_pc, 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        Reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
        #1 check("req_during_reset", imem_req, 1'b0);
        @(posedge CLK);
        #1;
        check("rst_valid", instr_valid, 1'b0);
        check("rst_occ", occupancy, 0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_addr", Instr_Addr, RESET_PC);
        Reset = 1'b1;
        m_q.delete(); m_fl.delete(); mem_q.delete();
        m_pc = RESET_PC; cyc = 0; grants = 0; delivered = 0;
    endtask

    vec_t vecs[12];

    initial begin
        // Streaming from reset, then back-pressure with ready low
        vecs[0]  = vec_t'{1, 0, 1, 1, 32'h00, 0, 32'h00, 0};
        vecs[1]  = vec_t'{1, 1, 1, 1, 32'h04, 0, 32'h00, 0};
        vecs[2]  = vec_t'{1, 1, 1, 1, 32'h08, 1, 32'h00, 1};
        vecs[3]  = vec_t'{1, 1, 1, 1, 32'h0C, 1, 32'h04, 1};
        vecs[4]  = vec_t'{1, 1, 1, 1, 32'h10, 1, 32'h08, 1};
        vecs[5]  = vec_t'{1, 1, 0, 1, 32'h14, 1, 32'h0C, 1};
        vecs[6]  = vec_t'{1, 1, 0, 1, 32'h18, 1, 32'h0C, 2};
        vecs[7]  = vec_t'{1, 1, 0, 0, 32'h1C, 1, 32'h0C, 3};
        vecs[8]  = vec_t'{1, 0, 1, 0, 32'h1C, 1, 32'h0C, 4};
        vecs[9]  = vec_t'{1, 0, 0, 1, 32'h1C, 1, 32'h10, 3};
        vecs[10] = vec_t'{1, 1, 0, 0, 32'h20, 1, 32'h10, 3};
        vecs[11] = vec_t'{1, 0, 0, 0, 32'h20, 1, 32'h10, 4};

        do_reset();
        foreach (vecs[i]) begin
            step(vecs[i].gnt, vecs[i].rv, vecs[i].rdy, 1'b0, 32'h0);
            check($sformatf("vec%0d_req", i), imem_req, vecs[i].exp_req);
            check($sformatf("vec%0d_addr", i), Instr_Addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_valid", i), instr_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_pc", i), instr_pc, vecs[i].exp_pc);
            check($sformatf("vec%0d_occ", i), occupancy, vecs[i].exp_occ);
            check($sformatf("vec%0d_instr", i), instr,
                  vecs[i].exp_valid ? mem_word(vecs[i].exp_pc) : 32'h0);
        end

        // Back-pressure from reset: exactly four grants, then one more after a single pop
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, rv_auto(), 1'b0, 1'b0, 32'h0);
        check("bp_grants", grants, 4);
        check("bp_occ", occupancy, 4);
        step(1'b1, rv_auto(), 1'b1, 1'b0, 32'h0);
        step(1'b1, rv_auto(), 1'b0, 1'b0, 32'h0);
        check("bp_occ_after_pop", occupancy, 3);
        check("bp_next_req", imem_req, 1'b1);
        check("bp_next_addr", Instr_Addr, 32'h10);

        // Wait states: address 0x8 holds while gnt is low
        do_reset();
        step(1'b1, rv_auto(), 1'b1, 1'b0, 32'h0);
        step(1'b1, rv_auto(), 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, rv_auto(), 1'b1, 1'b0, 32'h0);
            check("ws_hold_addr", Instr_Addr, 32'h8);
            check("ws_hold_req", imem_req, 1'b1);
        end
        step(1'b1, rv_auto(), 1'b1, 1'b0, 32'h0);
        step(1'b0, rv_auto(), 1'b1, 1'b0, 32'h0);
        check("ws_next_addr", Instr_Addr, 32'hC);
        for (int i = 0; i < 4; i++) step(1'b0, rv_auto(), 1'b1, 1'b0, 32'h0);
        check("ws_delivered", delivered, 3);

        // Redirect with two requests in flight, 3-cycle memory latency
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h103);
        check("rd_req_low", imem_req, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("rd_new_addr", Instr_Addr, 32'h100);
        check("rd_new_req", imem_req, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("rd_stale_dropped", instr_valid, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("rd_still_empty", instr_valid, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        check("rd_first_valid", instr_valid, 1'b1);
        check("rd_first_pc", instr_pc, 32'h100);
        check("rd_first_instr", instr, mem_word(32'h100));

        // Redirect coinciding with rvalid, gnt and a pop
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("sim_pre_occ", occupancy, 2);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        check("sim_occ_zero", occupancy, 0);
        check("sim_addr", Instr_Addr, 32'h200);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("sim_after_stale", instr_valid, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        check("sim_first_pc", instr_pc, 32'h200);
        check("sim_first_valid", instr_valid, 1'b1);

        // Reset in the middle of operation
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, rv_auto(), 1'b0, 1'b0, 32'h0);
        step(1'b0, rv_auto(), 1'b0, 1'b0, 32'h0);
        step(1'b0, rv_auto(), 1'b0, 1'b0, 32'h0);
        check("mid_occ", occupancy, 3);
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("mid_restart_addr", Instr_Addr, RESET_PC);
        check("mid_restart_req", imem_req, 1'b1);

        // Randomized traffic with variable latency
        mem_lat_max = 3;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) != 0,
                 rv_auto() && $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0,
                 $urandom());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
